sm_seq_mul: RTL and testbench

- Parametrised sequential sign-magnitude multiplier. Operand MSB is the sign (1 = negative); the remaining W-1 bits are the unsigned magnitude.
- Computes the magnitude product by iterative shift-add, one multiplier bit per clock. The sign is the XOR of the operand signs.
- Sits in the arithmetic unit beside the add/sub blocks. It is the clocked, width-generic successor to the small combinational multiplier, and adds a start/busy/done handshake and a correctly signed zero.

---
 rtl/sm_mul_pkg.sv | 22 ++
 rtl/sm_seq_mul_if.sv | 35 +++
 rtl/sm_mag_shift_add.sv | 84 ++++++++
 rtl/sm_seq_mul.sv | 104 ++++++++++
 tb/tb_sm_seq_mul.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sm_mul_pkg.sv
// ---------------------------------------------------------------------------
// sm_mul_pkg
// Shared types and helpers for the sign-magnitude sequential multiplier.
//   state_e    : FSM state encoding (IDLE, RUN)
//   MAX_W      : largest supported operand width (sign bit included)
//   cnt_width  : bits needed for the iteration counter of a W-bit operand
// ---------------------------------------------------------------------------
package sm_mul_pkg;

  localparam int MAX_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // The counter runs 0..W-2, so clog2(W) bits always suffice; never below 1.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/sm_seq_mul_if.sv
// ---------------------------------------------------------------------------
// sm_seq_mul_if
// Request/response bundle of the sequential sign-magnitude multiplier.
//   i_start        : request, honoured only while o_busy=0
//   i_A, i_B       : W-bit sign-magnitude operands, sampled on accept
//   o_busy         : operation in progress
//   o_done         : one-cycle pulse, o_res/o_Z valid
//   o_res          : RW-bit sign-magnitude product, held until next completion
//   o_Z            : zero-result flag, held with o_res
// Modports: master (requester side), slave (multiplier side).
// ---------------------------------------------------------------------------
interface sm_seq_mul_if #(
  parameter int W = 3
);
  localparam int RW = 2 * (W - 1) + 1;

  logic          i_start;
  logic [W-1:0]  i_A;
  logic [W-1:0]  i_B;
  logic          o_busy;
  logic          o_done;
  logic [RW-1:0] o_res;
  logic          o_Z;

  modport master (
    output i_start, i_A, i_B,
    input  o_busy, o_done, o_res, o_Z
  );

  modport slave (
    input  i_start, i_A, i_B,
    output o_busy, o_done, o_res, o_Z
  );

endinterface

// File: rtl/sm_mag_shift_add.sv
// ---------------------------------------------------------------------------
// sm_mag_shift_add
// Unsigned shift-add datapath for MW-bit magnitudes: one multiplier bit per
// step, accumulating into a 2*MW-bit register (cannot overflow).
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_load       : capture magnitudes, clear accumulator and counter
//   i_step       : perform one iteration
//   i_mag_a/b    : magnitudes to capture on i_load
//   o_acc_nxt    : accumulator value after the current iteration
//   o_last       : the current iteration is the final one
// Optional macro SM_SEQ_MUL_EARLY_TERM_EN: o_last also fires as soon as no
// set bits remain in the shifted multiplier.
// ---------------------------------------------------------------------------
module sm_mag_shift_add
  import sm_mul_pkg::*;
#(
  parameter int MW = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [MW-1:0]   i_mag_a,
  input  logic [MW-1:0]   i_mag_b,
  output logic [2*MW-1:0] o_acc_nxt,
  output logic            o_last
);

  localparam int CW = cnt_width(MW + 1);

  logic [MW-1:0]   mag_a_q, mag_a_d;
  logic [MW-1:0]   mag_b_q, mag_b_d;
  logic [2*MW-1:0] acc_q, acc_d;
  logic [2*MW-1:0] pp;
  logic [CW-1:0]   count_q, count_d;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    acc_d     = acc_q;
    count_d   = count_q;
    pp        = {{MW{1'b0}}, mag_a_q} << count_q;
    o_acc_nxt = acc_q + (mag_b_q[0] ? pp : '0);

    if (i_load) begin
      mag_a_d = i_mag_a;
      mag_b_d = i_mag_b;
      acc_d   = '0;
      count_d = '0;
    end else if (i_step) begin
      acc_d   = o_acc_nxt;
      mag_b_d = mag_b_q >> 1;
      count_d = count_q + CW'(1);
    end
  end

`ifdef SM_SEQ_MUL_EARLY_TERM_EN
  // Remaining multiplier bits all zero: further iterations add nothing.
  assign o_last = (count_q == CW'(MW - 1)) || ((mag_b_q >> 1) == '0);
`else
  assign o_last = (count_q == CW'(MW - 1));
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the datapath registers are cleared on reset even though i_load
  // overwrites them, so the post-reset state is fully deterministic.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mag_a_q <= '0;
      mag_b_q <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sm_seq_mul.sv
// ---------------------------------------------------------------------------
// sm_seq_mul
// Sequential sign-magnitude multiplier, W-bit operands (MSB = sign),
// RW = 2*(W-1)+1 bit sign-magnitude product. Magnitudes multiply by
// iterative shift-add (sm_mag_shift_add); the sign is the XOR of the operand
// signs, forced to 0 for a zero product so -0 is never produced.
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset
//   bus    : sm_seq_mul_if.slave (i_start, i_A, i_B, o_busy, o_done,
//            o_res, o_Z)
// Latency from accept edge to o_done is W-1 clocks. With the optional macro
// SM_SEQ_MUL_EARLY_TERM_EN it shortens to max(1, highest set bit of |B| + 1).
// ---------------------------------------------------------------------------
module sm_seq_mul
  import sm_mul_pkg::*;
#(
  parameter int W = 3
) (
  input logic         i_clk,
  input logic         i_rst,
  sm_seq_mul_if.slave bus
);

  localparam int MW = W - 1;
  localparam int RW = 2 * MW + 1;

  if (W < 2 || W > MAX_W) begin : g_bad_w
    $error("sm_seq_mul: W must be within 2..MAX_W");
  end

  state_e          state_q, state_d;
  logic            sgn_q, sgn_d;
  logic            done_q, done_d;
  logic            z_q, z_d;
  logic [RW-1:0]   res_q, res_d;
  logic            load, step, last;
  logic [2*MW-1:0] acc_nxt;

  sm_mag_shift_add #(
    .MW (MW)
  ) u_dp (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (load),
    .i_step    (step),
    .i_mag_a   (bus.i_A[W-2:0]),
    .i_mag_b   (bus.i_B[W-2:0]),
    .o_acc_nxt (acc_nxt),
    .o_last    (last)
  );

  always_comb begin
    state_d = state_q;
    sgn_d   = sgn_q;
    done_d  = 1'b0;
    res_d   = res_q;
    z_d     = z_q;
    load    = 1'b0;
    step    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          load    = 1'b1;
          sgn_d   = bus.i_A[W-1] ^ bus.i_B[W-1];
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          z_d     = (acc_nxt == '0);
          // Zero product keeps a positive sign.
          res_d   = {sgn_q & (acc_nxt != '0), acc_nxt};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      sgn_q   <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      z_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      done_q  <= done_d;
      res_q   <= res_d;
      z_q     <= z_d;
    end
  end

  assign bus.o_busy = (state_q == RUN);
  assign bus.o_done = done_q;
  assign bus.o_res  = res_q;
  assign bus.o_Z    = z_q;

endmodule

// File: tb/tb_sm_seq_mul.sv
// ---------------------------------------------------------------------------
// tb_sm_seq_mul
// Self-checking bench for sm_seq_mul at W=3 and W=8. Expected products are
// pushed to per-DUT scoreboard queues when a request is driven and compared
// (value, zero flag, completion cycle) when o_done is seen. Honors
// SM_SEQ_MUL_EARLY_TERM_EN when computing expected latency.
// ---------------------------------------------------------------------------
module tb_sm_seq_mul;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          at;
  } exp_t;

  logic clk = 1'b0;
  logic rst3;
  logic rst8;
  int   cycle    = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t q3[$];
  exp_t q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  sm_seq_mul_if #(.W(3)) bus3 ();
  sm_seq_mul_if #(.W(8)) bus8 ();

  sm_seq_mul #(.W(3)) u_dut3 (.i_clk(clk), .i_rst(rst3), .bus(bus3));
  sm_seq_mul #(.W(8)) u_dut8 (.i_clk(clk), .i_rst(rst8), .bus(bus8));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
  endtask

  function automatic int exp_lat(input int w, input logic [31:0] b);
    logic [31:0] mb;
    int          h;
    mb = b & ((32'd1 << (w - 1)) - 32'd1);
    h  = 0;
    for (int i = 0; i < w - 1; i++) if (mb[i]) h = i + 1;
`ifdef SM_SEQ_MUL_EARLY_TERM_EN
    return (h == 0) ? 1 : h;
`else
    return w - 1;
`endif
  endfunction

  function automatic logic [31:0] model_res(input int w, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mask, p;
    logic        s;
    mask = (32'd1 << (w - 1)) - 32'd1;
    p    = (a & mask) * (b & mask);
    s    = a[w-1] ^ b[w-1];
    if (p == 32'd0) s = 1'b0;
    return p | (32'(s) << (2 * (w - 1)));
  endfunction

  // Scoreboard monitors: sample at negedge, away from the active edge.
  always @(negedge clk) begin : mon3
    exp_t e;
    if (bus3.o_done) begin
      check("w3_done_expected", 32'(q3.size() != 0), 32'd1);
      if (q3.size() != 0) begin
        e = q3.pop_front();
        check("w3_res", 32'(bus3.o_res), e.res);
        check("w3_z", 32'(bus3.o_Z), 32'(e.z));
        check("w3_done_cycle", 32'(cycle), 32'(e.at));
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (bus8.o_done) begin
      check("w8_done_expected", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        check("w8_res", 32'(bus8.o_res), e.res);
        check("w8_z", 32'(bus8.o_Z), 32'(e.z));
        check("w8_done_cycle", 32'(cycle), 32'(e.at));
      end
    end
  end

  // issueN: caller is just past a posedge; drive a one-cycle start and log it.
  task automatic issue3(input logic [2:0] a, input logic [2:0] b, input logic [31:0] er, input logic ez);
    exp_t e;
    bus3.i_start = 1'b1; bus3.i_A = a; bus3.i_B = b;
    e.res = er; e.z = ez; e.at = cycle + 1 + exp_lat(3, 32'(b));
    q3.push_back(e);
    @(posedge clk); #1;
    bus3.i_start = 1'b0; bus3.i_A = 3'($urandom); bus3.i_B = 3'($urandom);
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [31:0] er, input logic ez);
    exp_t e;
    bus8.i_start = 1'b1; bus8.i_A = a; bus8.i_B = b;
    e.res = er; e.z = ez; e.at = cycle + 1 + exp_lat(8, 32'(b));
    q8.push_back(e);
    @(posedge clk); #1;
    bus8.i_start = 1'b0; bus8.i_A = 8'($urandom); bus8.i_B = 8'($urandom);
  endtask

  task automatic start3(input logic [2:0] a, input logic [2:0] b, input logic [31:0] er, input logic ez);
    @(posedge clk); #1;
    issue3(a, b, er, ez);
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic [31:0] er, input logic ez);
    @(posedge clk); #1;
    issue8(a, b, er, ez);
  endtask

  task automatic wait3();
    int n = 0;
    while ((bus3.o_busy || q3.size() != 0) && n < 40) begin @(negedge clk); n++; end
    check("w3_completes", 32'(n < 40), 32'd1);
  endtask

  task automatic wait8();
    int n = 0;
    while ((bus8.o_busy || q8.size() != 0) && n < 40) begin @(negedge clk); n++; end
    check("w8_completes", 32'(n < 40), 32'd1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    vec_t t3[6];
    vec_t t8[8];
    logic [7:0] ra, rb;
    logic [31:0] mr;
    int n;

    t3[0] = '{32'h3, 32'h7, 32'h19, 1'b0};   // +3 * -3 = -9
    t3[1] = '{32'h4, 32'h3, 32'h00, 1'b1};   // -0 * +3 = 0
    t3[2] = '{32'h2, 32'h6, 32'h14, 1'b0};   // +2 * -2 = -4
    t3[3] = '{32'h1, 32'h1, 32'h01, 1'b0};   // +1 * +1 = +1
    t3[4] = '{32'h7, 32'h7, 32'h09, 1'b0};   // -3 * -3 = +9
    t3[5] = '{32'h5, 32'h0, 32'h00, 1'b1};   // -1 * +0 = 0

    t8[0] = '{32'h85, 32'h07, 32'h4023, 1'b0};  // -5 * +7 = -35
    t8[1] = '{32'h7F, 32'h7F, 32'h3F01, 1'b0};  // 127 * 127
    t8[2] = '{32'hFF, 32'hFF, 32'h3F01, 1'b0};  // -127 * -127
    t8[3] = '{32'h80, 32'h85, 32'h0000, 1'b1};  // -0 * -5 = 0
    t8[4] = '{32'h03, 32'h00, 32'h0000, 1'b1};  // +3 * +0 = 0
    t8[5] = '{32'h0A, 32'hC0, 32'h4280, 1'b0};  // +10 * -64 = -640
    t8[6] = '{32'h81, 32'h01, 32'h4001, 1'b0};  // -1 * +1 = -1
    t8[7] = '{32'h7F, 32'hC0, 32'h5FC0, 1'b0};  // 127 * -64 = -8128

    rst3 = 1'b1; rst8 = 1'b1;
    bus3.i_start = 1'b0; bus3.i_A = '0; bus3.i_B = '0;
    bus8.i_start = 1'b0; bus8.i_A = '0; bus8.i_B = '0;
    repeat (2) @(posedge clk);
    #1; rst3 = 1'b0; rst8 = 1'b0;

    // Reset state.
    @(negedge clk);
    check("w3_rst_res", 32'(bus3.o_res), 32'h0);
    check("w3_rst_z", 32'(bus3.o_Z), 32'h1);
    check("w3_rst_busy", 32'(bus3.o_busy), 32'h0);
    check("w3_rst_done", 32'(bus3.o_done), 32'h0);
    check("w8_rst_res", 32'(bus8.o_res), 32'h0);
    check("w8_rst_z", 32'(bus8.o_Z), 32'h1);
    check("w8_rst_busy", 32'(bus8.o_busy), 32'h0);
    check("w8_rst_done", 32'(bus8.o_done), 32'h0);

    // W=3 handshake timing: busy for the latency, then a one-cycle done.
    start3(3'b011, 3'b111, 32'h19, 1'b0);
    for (int i = 0; i < exp_lat(3, 32'h7); i++) begin
      @(negedge clk);
      check("w3_busy_run", 32'(bus3.o_busy), 32'h1);
      check("w3_no_early_done", 32'(bus3.o_done), 32'h0);
    end
    @(negedge clk);
    check("w3_busy_at_done", 32'(bus3.o_busy), 32'h0);
    check("w3_done_pulse", 32'(bus3.o_done), 32'h1);
    @(negedge clk);
    check("w3_done_drops", 32'(bus3.o_done), 32'h0);
    check("w3_res_held", 32'(bus3.o_res), 32'h19);
    wait3();

    // Table vectors.
    for (int i = 0; i < 6; i++) begin
      start3(3'(t3[i].a), 3'(t3[i].b), t3[i].res, t3[i].z);
      wait3();
    end
    for (int i = 0; i < 8; i++) begin
      start8(8'(t8[i].a), 8'(t8[i].b), t8[i].res, t8[i].z);
      wait8();
    end

    // W=3 exhaustive and W=8 random against the model.
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        mr = model_res(3, 32'(a), 32'(b));
        start3(3'(a), 3'(b), mr, mr == 32'd0);
        wait3();
      end
    end
    for (int i = 0; i < 10; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      mr = model_res(8, 32'(ra), 32'(rb));
      start8(ra, rb, mr, mr == 32'd0);
      wait8();
    end

    // Start while busy is ignored; start in the done cycle is accepted.
    start8(8'h85, 8'h07, 32'h4023, 1'b0);
    bus8.i_start = 1'b1; bus8.i_A = 8'h7F; bus8.i_B = 8'h7F;
    @(posedge clk); #1;
    bus8.i_start = 1'b0;
    n = 0;
    while (!bus8.o_done && n < 20) begin @(posedge clk); #1; n++; end
    check("w8_first_done_seen", 32'(bus8.o_done), 32'h1);
    issue8(8'h8A, 8'h0C, 32'h4078, 1'b0);      // -10 * +12 = -120
    @(negedge clk);
    check("w8_b2b_done_drop", 32'(bus8.o_done), 32'h0);
    check("w8_b2b_busy", 32'(bus8.o_busy), 32'h1);
    check("w8_b2b_res_held", 32'(bus8.o_res), 32'h4023);
    wait8();

    // Reset during the 4th RUN cycle aborts with no completion.
    start8(8'h05, 8'h7F, 32'h027B, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("w8_busy_before_abort", 32'(bus8.o_busy), 32'h1);
    rst8 = 1'b1;
    q8.delete();
    @(posedge clk); #1;
    rst8 = 1'b0;
    @(negedge clk);
    check("w8_abort_busy", 32'(bus8.o_busy), 32'h0);
    check("w8_abort_done", 32'(bus8.o_done), 32'h0);
    check("w8_abort_res", 32'(bus8.o_res), 32'h0);
    check("w8_abort_z", 32'(bus8.o_Z), 32'h1);
    repeat (10) @(negedge clk);
    start8(8'h83, 8'h82, 32'h0006, 1'b0);       // -3 * -2 = +6
    wait8();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(q3.size() + q8.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
